serial_accumulator: RTL
=======================

// Module: serial_accumulator
// PURPOSE
//  Bit-serial unsigned accumulator built around the existing 1-bit full adder (adder).
//  Accepts W-bit operands over a valid/ready handshake and adds each one LSB-first into a W-bit accumulator.
//  It processes one bit per clock, keeping the carry in a flop between bits.
//  Sits directly downstream of adder: it consumes adder's s/cout each cycle and publishes the running sum.
// PARAMETERS
//  W  8  operand/accumulator width in bits; legal range W >= 2
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  clear      in   1  synchronous clear of accumulator, overflow and FSM; beats in_valid
//  in_valid   in   1  operand available on in_data
//  in_ready   out  1  block can accept an operand this cycle
//  in_data    in   W  unsigned operand
//  acc_out    out  W  last completed accumulator value; stable between out_valid pulses
//  out_valid  out  1  one-cycle pulse: acc_out/overflow just updated
//  overflow   out  1  sticky: some addition since last rst/clear produced carry-out
//  busy       out  1  high in S_ADD and S_DONE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=S_IDLE.
//    acc_out=0, work register=0, overflow=0, carry=0, bit count=0, out_valid=0.
//    in_ready=0 while rst=1; busy=0.
//  FSM states S_IDLE, S_ADD, S_DONE.
//  - S_IDLE: in_ready = !clear.
//    On in_valid & in_ready: operand shift reg <= in_data; work reg <= acc_out; carry <= 0; cnt <= 0; go to S_ADD.
//  - S_ADD: adder inputs are a=work[0], b=opnd[0], cin=carry.
//    Each edge: work <= {s, work[W-1:1]}; opnd <= opnd>>1; carry <= cout; cnt++.
//    When cnt==W-1, take that edge's update and go to S_DONE.
//  - S_DONE: acc_out <= work; overflow <= overflow | carry; out_valid=1 for that cycle; go to S_IDLE.
//  Latency: operand accepted at edge E; out_valid is sampled high at edge E+W+1 with the new acc_out.
//    Back-to-back throughput is one operand per W+2 cycles.
//  in_ready=0 in S_ADD/S_DONE. in_valid held during that time is not lost and not double-accepted.
//    It is taken at the first S_IDLE edge.
//  Arithmetic is modulo 2^W. Final carry goes only to overflow, never into acc_out.
//  clear=1 at any edge, any state: next state S_IDLE; acc_out, work and overflow become 0; carry=0.
//    No out_valid is produced for an aborted operand, and clear+in_valid accepts nothing.
//  rst mid-operation: identical to clear, plus all outputs take their reset values; rst has priority over clear.
//  out_valid and in_ready are never high in the same cycle.
// STRUCTURE
//  Shared package addac_pkg:
//    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} acc_state_t;
//    localparam ADDAC_DEFAULT_W = 8.
//  One sub-module: instance of the existing 1-bit full adder
//    adder u_fa(.a, .b, .cin, .s, .cout), purely combinational.
//  Local logic: FSM, operand shift register, work register, carry flop,
//    $clog2(W)-bit bit counter, acc_out/overflow registers.
// TESTING (W=8; expected values checked with !==, errors counted and reported)
//  1 Reset: rst=1 for 2 cycles -> acc_out=8'h00, overflow=0, out_valid=0, busy=0; in_ready=1 once rst=0.
//  2 Accumulate: push 8'h05, then 8'h0A -> acc_out=8'h05, then 8'h0F; overflow=0;
//    each out_valid exactly 9 edges after its acceptance.
//  3 Overflow: from 0, push 8'hF0, then 8'h20 -> acc_out=8'h10, overflow=1;
//    then push 8'h01 -> acc_out=8'h11, overflow still 1.
//  4 Backpressure: hold in_valid=1 with 8'h03 for 20 cycles from acc 0 ->
//    in_ready low during S_ADD/S_DONE; two acceptances spaced 10 edges apart; acc_out 8'h03 then 8'h06.
//  5 Clear mid-op: acc=8'h40, push 8'h40, assert clear at 3rd S_ADD edge ->
//    next cycle S_IDLE, acc_out=8'h00, overflow=0, no out_valid pulse follows.
//  6 Exhaustive carry chain: from 8'hFF push 8'h01 -> acc_out=8'h00, overflow=1;
//    rst mid-op on a following operand -> all outputs return to reset values.

Source files
------------

// File: rtl/addac_pkg.sv
// Shared definitions for the bit-serial accumulator.
//   acc_state_t     : accumulator FSM state encoding
//   ADDAC_DEFAULT_W : default operand/accumulator width
package addac_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } acc_state_t;

  localparam int ADDAC_DEFAULT_W = 8;

endpackage : addac_pkg

// File: rtl/serial_accumulator_adder.sv
// 1-bit full adder, purely combinational.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : adder

// File: rtl/serial_accumulator.sv
// Bit-serial unsigned accumulator. Each accepted operand is added LSB-first,
// one bit per clock, into a W-bit accumulator through a single full adder.
//   clk, rst            : clock, synchronous active-high reset
//   clear               : synchronous clear of accumulator, overflow and FSM
//   in_valid / in_ready : operand handshake, in_data is the operand
//   acc_out             : last completed accumulator value
//   out_valid           : one-cycle pulse, acc_out/overflow just updated
//   overflow            : sticky carry-out since last rst/clear
//   busy                : operand in flight (S_ADD or S_DONE)
//
// state  | meaning
// S_IDLE | waiting for an operand, in_ready high unless clear
// S_ADD  | one operand bit per clock through the full adder
// S_DONE | result published, out_valid high for this cycle
module serial_accumulator
  import addac_pkg::*;
#(
  parameter int W = ADDAC_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] acc_out,
  output logic         out_valid,
  output logic         overflow,
  output logic         busy
);

  localparam int CNT_W = $clog2(W);

  acc_state_t state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s, fa_cout;

  adder u_fa (
    .a    (work_q[0]),
    .b    (opnd_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == S_IDLE) && !clear && !rst;
    out_valid = (state_q == S_DONE) && !clear && !rst;
    busy      = (state_q == S_ADD) || (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          opnd_d  = in_data;
          work_d  = acc_q;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        work_d  = {fa_s, work_q[W-1:1]};
        opnd_d  = opnd_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          // Register the result on the last bit edge so acc_out is already
          // valid during the S_DONE cycle that carries the out_valid pulse.
          acc_d   = work_d;
          ovf_d   = ovf_q | fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear) begin
      state_d = S_IDLE;
      work_d  = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule : serial_accumulator
